uart_rx_param: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 8N1 receiver. Serial rx -> parallel word.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 3-sample majority vote, baud divider calculation.
// The state encoding widens to 3 bits when UART_RX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;
`endif

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1 and pulses tick_c at terminal count; hold parks it at 0.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic hold,
    output logic tick_c
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (hold || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_c = !hold && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with input sync, majority-vote sampling and valid/ready output.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CLK_FREQ_HZ = 125_000_000,
    parameter int unsigned BAUDRATE    = 115200,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  overrun_o
);

    localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUDRATE, OVERSAMPLE);
    localparam int unsigned SCW      = $clog2(OVERSAMPLE);
    localparam int unsigned BCW      = $clog2(DATA_WIDTH);
    localparam logic [SCW-1:0] S_A    = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] S_B    = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] S_C    = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] B_LAST    = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_rx_param: DATA_WIDTH must be 5..9");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_par
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("uart_rx_param: clock too slow for BAUDRATE*OVERSAMPLE");
    end

    // Two-stage synchroniser plus one history stage for falling-edge detection.
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    uart_state_e           state_q, state_d;
    logic [SCW-1:0]        samp_q, samp_d;
    logic [BCW-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_d, busy_d, frame_err_d, overrun_d;
    logic                  tick_c, vote_c, commit_c;

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .hold   (state_q == ST_IDLE),
        .tick_c (tick_c)
    );

    assign vote_c = majority3(s0_q, s1_q, rx_sync);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        ferr_d      = ferr_q;
        commit_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_o;
`endif
        data_d      = data_o;
        valid_d     = valid_o && !ready_i;
        frame_err_d = frame_err_o;
        overrun_d   = 1'b0;

        if (tick_c) begin
            samp_d = (samp_q == S_LAST) ? '0 : samp_q + SCW'(1);
            if (samp_q == S_A) s0_d = rx_sync;
            if (samp_q == S_B) s1_d = rx_sync;
        end

        // Vote lands on the tick at sample S_C; bit boundaries fall on the S_LAST tick.
        unique case (state_q)
            ST_IDLE: begin
                samp_d = '0;
                bit_d  = '0;
                if (rx_prev && !rx_sync) begin
                    state_d = ST_START;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick_c && samp_q == S_C && vote_c) state_d = ST_IDLE;
                else if (tick_c && samp_q == S_LAST)   state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick_c && samp_q == S_C) shift_d = {vote_c, shift_q[DATA_WIDTH-1:1]};
                if (tick_c && samp_q == S_LAST) begin
                    if (bit_q == B_LAST) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BCW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_c && samp_q == S_C)    par_d   = vote_c;
                if (tick_c && samp_q == S_LAST) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick_c && samp_q == S_C) begin
                    if (!vote_c) ferr_d = 1'b1;
                    if (bit_q == STOP_LAST) begin
                        commit_c = 1'b1;
                        bit_d    = '0;
                        state_d  = ST_IDLE;
                    end
                end else if (tick_c && samp_q == S_LAST) begin
                    bit_d = bit_q + BCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pending unaccepted word wins; the new one is dropped and flagged.
        if (commit_c) begin
            if (valid_o && !ready_i) begin
                overrun_d = 1'b1;
            end else begin
                valid_d     = 1'b1;
                data_d      = shift_q;
                frame_err_d = ferr_q | !vote_c;
`ifdef UART_RX_PARITY_EN
                parity_err_d = par_q ^ (^shift_q) ^ 1'(PARITY_ODD);
`endif
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            samp_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            ferr_q      <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            ferr_q      <= ferr_d;
            data_o      <= data_d;
            valid_o     <= valid_d;
            busy_o      <= busy_d;
            frame_err_o <= frame_err_d;
            overrun_o   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_q        <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_o <= parity_err_d;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param at 16 clk/bit; parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

    localparam int unsigned BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, busy_o, frame_err_o, parity_err_o, overrun_o;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_WIDTH  (8),
        .CLK_FREQ_HZ (16_000_000),
        .BAUDRATE    (1_000_000),
        .OVERSAMPLE  (16),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx           (rx),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    int checks = 0;
    int failures = 0;

    // Passive monitor: accepted words, overrun pulses, busy cycles, busy around valid rise.
    int         acc_cnt = 0, ovr_cnt = 0, rise_cnt = 0, busy_cnt = 0;
    logic [7:0] last_data = '0;
    logic       last_ferr = 1'b0, last_perr = 1'b0;
    logic       rise_busy = 1'b1, rise_busy_prev = 1'b0;
    logic       valid_prev = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            acc_cnt   = acc_cnt + 1;
            last_data = data_o;
            last_ferr = frame_err_o;
            last_perr = parity_err_o;
        end
        if (overrun_o) ovr_cnt = ovr_cnt + 1;
        if (busy_o) busy_cnt = busy_cnt + 1;
        if (valid_o && !valid_prev) begin
            rise_cnt       = rise_cnt + 1;
            rise_busy      = busy_o;
            rise_busy_prev = busy_prev;
        end
        valid_prev = valid_o;
        busy_prev  = busy_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v);
`else
        if (par_v === 1'bx) rx = 1'b1;
`endif
        drive_bit(stop_v);
        rx = 1'b1;
    endtask

    int a0, r0, b0, o0;

    initial begin
        // Reset values
        idle(3);
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ferr", 32'(frame_err_o), 32'd0);
        chk("rst_perr", 32'(parity_err_o), 32'd0);
        chk("rst_ovr", 32'(overrun_o), 32'd0);
        rstn = 1'b1;
        idle(10);

        // 0x41, clean frame, consumer ready
        a0 = acc_cnt; r0 = rise_cnt;
        send_frame(8'h41, 1'b1, 1'b0);
        idle(20);
        chk("t1_accepts", 32'(acc_cnt - a0), 32'd1);
        chk("t1_rises", 32'(rise_cnt - r0), 32'd1);
        chk("t1_data", 32'(last_data), 32'h41);
        chk("t1_ferr", 32'(last_ferr), 32'd0);
        chk("t1_perr", 32'(last_perr), 32'd0);
        chk("t1_busy_at_valid", 32'(rise_busy), 32'd0);
        chk("t1_busy_before_valid", 32'(rise_busy_prev), 32'd1);
        chk("t1_busy_end", 32'(busy_o), 32'd0);

        // False start: 4 clk glitch
        a0 = acc_cnt; b0 = busy_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        chk("t2_busy_seen", 32'(busy_cnt > b0), 32'd1);
        chk("t2_busy_end", 32'(busy_o), 32'd0);
        chk("t2_accepts", 32'(acc_cnt - a0), 32'd0);

        // 0x55 with a 0 stop bit
        a0 = acc_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        idle(20);
        chk("t3_accepts", 32'(acc_cnt - a0), 32'd1);
        chk("t3_data", 32'(last_data), 32'h55);
        chk("t3_ferr", 32'(last_ferr), 32'd1);

        // Back-to-back 0xA5, 0x3C with consumer stalled
        ready_i = 1'b0;
        a0 = acc_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        chk("t4_overruns", 32'(ovr_cnt - o0), 32'd1);
        chk("t4_valid_held", 32'(valid_o), 32'd1);
        chk("t4_data_kept", 32'(data_o), 32'hA5);
        chk("t4_ferr", 32'(frame_err_o), 32'd0);
        ready_i = 1'b1;
        idle(3);
        chk("t4_accepts", 32'(acc_cnt - a0), 32'd1);
        chk("t4_acc_data", 32'(last_data), 32'hA5);
        chk("t4_valid_drop", 32'(valid_o), 32'd0);

        // Break: line low well beyond one frame
        a0 = acc_cnt;
        rx = 1'b0;
        idle(BIT_CLKS * 12);
        rx = 1'b1;
        idle(40);
        chk("brk_accepts", 32'(acc_cnt - a0), 32'd1);
        chk("brk_data", 32'(last_data), 32'h00);
        chk("brk_ferr", 32'(last_ferr), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07 (three ones): parity bit must be 1
        a0 = acc_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        chk("par_bad_accepts", 32'(acc_cnt - a0), 32'd1);
        chk("par_bad_perr", 32'(last_perr), 32'd1);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        chk("par_ok_data", 32'(last_data), 32'h07);
        chk("par_ok_perr", 32'(last_perr), 32'd0);
`endif

        // Reset mid-DATA, then a clean 0x81
        a0 = acc_cnt;
        rx = 1'b0;
        idle(BIT_CLKS * 4);
        rstn = 1'b0;
        rx = 1'b1;
        idle(2);
        @(negedge clk);
        chk("t6_rst_valid", 32'(valid_o), 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_data", 32'(data_o), 32'd0);
        chk("t6_rst_ferr", 32'(frame_err_o), 32'd0);
        rstn = 1'b1;
        idle(40);
        chk("t6_aborted", 32'(acc_cnt - a0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        chk("t6_accepts", 32'(acc_cnt - a0), 32'd1);
        chk("t6_data", 32'(last_data), 32'h81);
        chk("t6_ferr", 32'(last_ferr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
